// File: rtl/button_conditioner_if.sv
// Signal bundle between the raw board inputs and the conditioned outputs
// of button_conditioner. The conditioner takes the slave side. The
// consumer, which drives raw and reads the conditioned outputs, takes the
// master side.
interface button_conditioner_if #(
    parameter int N = 4
) ();

    logic [N-1:0] raw;
    logic [N-1:0] level;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] toggle;
    logic [N-1:0] press;

    modport master (
        output raw,
        input  level,
        input  rise,
        input  fall,
        input  toggle,
        input  press
    );

    modport slave (
        input  raw,
        output level,
        output rise,
        output fall,
        output toggle,
        output press
    );

endinterface

// File: rtl/button_conditioner.sv
// Push-button / slide-switch conditioner.
// The same logic is built once for each of the N independent channels:
// a two-flop synchronizer, a debounce counter that resets on agreement,
// registered rise/fall pulses, a toggle state and a hold-to-repeat FSM
// whose pulses are merged with rise into press.
//
// Repeat FSM states:
//   ST_IDLE   | level low, or waiting for a rising edge
//   ST_HOLD   | level high since rise, counting toward first repeat
//   ST_REPEAT | first repeat emitted, pulsing every REPEAT_CYCLES
module button_conditioner #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000
) (
    input  logic                 clk,
    input  logic                 btnc,
    button_conditioner_if.slave  bus
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RP_W   = $clog2(RP_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] HOLD_LAST = RP_W'(HOLD_CYCLES - 1);
    localparam logic [RP_W-1:0] REP_LAST  = RP_W'(REPEAT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    for (genvar i = 0; i < N; i++) begin : g_ch

        logic            sync1;
        logic            sync2;
        logic            level_q;
        logic            rise_q;
        logic            fall_q;
        logic            toggle_q;
        logic            press_q;
        logic [DB_W-1:0] db_cnt;
        logic [RP_W-1:0] rp_cnt;
        logic [1:0]      state;

        logic            level_next;
        logic [DB_W-1:0] db_cnt_next;
        logic [1:0]      state_next;
        logic [RP_W-1:0] rp_cnt_next;
        logic            rep_pulse;
        logic            rise_next;
        logic            fall_next;

        // Two-flop synchronizer; only sync2 feeds the rest of the channel.
        always_ff @(posedge clk) begin
            if (btnc) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
            end else begin
                sync1 <= bus.raw[i];
                sync2 <= sync1;
            end
        end

        // Debounce: count consecutive disagreements; any agreement restarts.
        always_comb begin
            level_next  = level_q;
            db_cnt_next = '0;
            if (sync2 != level_q) begin
                if (db_cnt == DB_LAST) begin
                    level_next = sync2;
                end else begin
                    db_cnt_next = db_cnt + DB_W'(1);
                end
            end
        end

        assign rise_next = level_next & ~level_q;
        assign fall_next = ~level_next & level_q;

        // Repeat FSM follows the level being registered this cycle, so a
        // release edge drops straight to idle without emitting a pulse.
        always_comb begin
            state_next  = state;
            rp_cnt_next = rp_cnt;
            rep_pulse   = 1'b0;
            if (!level_next) begin
                state_next  = ST_IDLE;
                rp_cnt_next = '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!level_q) begin
                            state_next  = ST_HOLD;
                            rp_cnt_next = '0;
                        end
                    end
                    ST_HOLD: begin
                        if (rp_cnt == HOLD_LAST) begin
                            rep_pulse   = 1'b1;
                            rp_cnt_next = '0;
                            state_next  = ST_REPEAT;
                        end else begin
                            rp_cnt_next = rp_cnt + RP_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (rp_cnt == REP_LAST) begin
                            rep_pulse   = 1'b1;
                            rp_cnt_next = '0;
                        end else begin
                            rp_cnt_next = rp_cnt + RP_W'(1);
                        end
                    end
                    default: begin
                        state_next  = ST_IDLE;
                        rp_cnt_next = '0;
                    end
                endcase
            end
        end

        // Channel state and registered pulses; reset overrides everything.
        always_ff @(posedge clk) begin
            if (btnc) begin
                level_q  <= 1'b0;
                db_cnt   <= '0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
                toggle_q <= 1'b0;
                press_q  <= 1'b0;
                state    <= ST_IDLE;
                rp_cnt   <= '0;
            end else begin
                level_q  <= level_next;
                db_cnt   <= db_cnt_next;
                rise_q   <= rise_next;
                fall_q   <= fall_next;
                toggle_q <= toggle_q ^ rise_next;
                press_q  <= rise_next | rep_pulse;
                state    <= state_next;
                rp_cnt   <= rp_cnt_next;
            end
        end

        assign bus.level[i]  = level_q;
        assign bus.rise[i]   = rise_q;
        assign bus.fall[i]   = fall_q;
        assign bus.toggle[i] = toggle_q;
        assign bus.press[i]  = press_q;

    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input-conditioning stage that sits directly upstream of the stopwatch timer on the Basys3-class board. It takes the raw, asynchronous push-button and slide-switch inputs and produces clean, synchronous levels, single-cycle edge pulses, per-channel toggle states and hold-to-repeat pulses. The timer and display logic consume these in place of raw pins for start/stop, lap and digit-set controls.

## Interface
- N, 4, number of independent input channels (≥1)
- DEBOUNCE_CYCLES, 1_000_000, consecutive cycles an input must differ from its accepted level before the level changes (10 ms at 100 MHz; ≥1)
- HOLD_CYCLES, 50_000_000, cycles a level must stay high after its rising edge before the first repeat pulse (≥1)
- REPEAT_CYCLES, 10_000_000, period of subsequent repeat pulses while held (≥1)

- clk  in  1  system clock, all logic on rising edge
- btnc  in  1  synchronous, active-high reset
- raw  in  N  asynchronous button/switch inputs, active-high
- level  out  N  debounced level
- rise  out  N  one-cycle pulse on level 0→1
- fall  out  N  one-cycle pulse on level 1→0
- toggle  out  N  flips on every rise
- press  out  N  rise OR repeat pulse (auto-repeat strobe)

## Operation
- Per channel, fully independent; identical logic replicated N times.
- Synchronizer: two flops, sync1 ← raw, sync2 ← sync1. Only sync2 is used downstream.
- Debounce counter, width $clog2(DEBOUNCE_CYCLES+1):
  - sync2 == level: counter cleared to 0.
  - sync2 != level and counter < DEBOUNCE_CYCLES-1: counter +1.
  - sync2 != level and counter == DEBOUNCE_CYCLES-1: level ← sync2, counter ← 0.
  - Any single cycle of agreement restarts the count (glitch rejection).
- Edge pulses registered: rise/fall asserted in the same cycle level first shows its new value, deasserted the next cycle.
- toggle inverts on the same edge that sets rise.
- Repeat FSM, states IDLE, HOLD, REPEAT; repeat counter width $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1):
  - IDLE: on level rising → HOLD, counter 0.
  - HOLD: counter +1 each cycle; at HOLD_CYCLES-1 emit repeat pulse, counter 0 → REPEAT.
  - REPEAT: counter +1; at REPEAT_CYCLES-1 emit repeat pulse, counter 0, stay.
  - Any state: level low → IDLE, counter 0, no pulse that cycle.
- press = rise | repeat pulse, registered alongside rise (never two-cycle wide).

## Timing
- Reset (btnc high at an edge): sync1, sync2, level, rise, fall, toggle, press, all counters = 0, FSM IDLE. Takes priority over all other updates.
- Latency: if raw is first sampled at its new value on edge k and stays stable, level changes on edge k+DEBOUNCE_CYCLES+1.
- First repeat pulse HOLD_CYCLES cycles after rise; subsequent pulses every REPEAT_CYCLES cycles.
- raw high during and after reset: treated as a normal press; level rises DEBOUNCE_CYCLES+2 edges after reset deasserts (sync pipeline refill), with rise/toggle/press.
- Reset mid-debounce or mid-repeat: count discarded, no pulses emitted on the reset edge or the edge after.
- Release during HOLD: no repeat pulse; fall pulses normally.

## Test plan
- DEBOUNCE_CYCLES=4: raw[0] 0→1 sampled at edge 10, held → level[0] high at edge 15, rise[0] and press[0] high only for cycle after edge 15, toggle[0]=1.
- Glitch: raw[1] high for 3 cycles then low, DEBOUNCE_CYCLES=4 → level[1], rise[1], press[1] never assert; counter returns to 0.
- Bounce: raw[2] toggles every cycle for 20 cycles then stays high → exactly one rise[2], level[2] high 5 edges after last transition sampled.
- Auto-repeat: DEBOUNCE=4, HOLD=8, REPEAT=3, raw[3] held 30 cycles → press[3] at rise cycle t, then t+8, t+11, t+14, ...; release → fall[3] once, no further press.
- Toggle: two separate clean presses on channel 0 → toggle[0] 0→1→0; level/fall consistent.
- Reset mid-hold: assert btnc while in REPEAT with raw high → all outputs 0 next cycle; after deassert with raw still high, level rises after DEBOUNCE_CYCLES+2 edges with a fresh rise and toggle=1.
